// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin share of one ALU between NUM_REQ requesters.
// One operation in flight; result returned tagged with the owner index.
module alu_req_arbiter #(
  parameter int NUM_REQ              = 4,
  parameter int ALU_IN_OP_WIDTH      = 3,
  parameter int ALU_IN_OPERAND_WIDTH = 8,
  parameter int ALU_OUT_RESULT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES       = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*ALU_IN_OP_WIDTH-1:0]      req_op,
  input  logic [NUM_REQ*ALU_IN_OPERAND_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ALU_IN_OPERAND_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic                                    rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]              rsp_id,
  output logic [ALU_OUT_RESULT_WIDTH-1:0]         rsp_result,
  output logic                                    rsp_error,
  input  logic                                    alu_ready,
  output logic                                    alu_valid,
  output logic [ALU_IN_OP_WIDTH-1:0]              alu_op,
  output logic [ALU_IN_OPERAND_WIDTH-1:0]         alu_a,
  output logic [ALU_IN_OPERAND_WIDTH-1:0]         alu_b,
  input  logic                                    alu_done,
  input  logic [ALU_OUT_RESULT_WIDTH-1:0]         alu_result
);

  localparam int OW = ALU_IN_OP_WIDTH;
  localparam int DW = ALU_IN_OPERAND_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, next;

  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic [IW:0]   sum;
  logic          found;
  logic [CW-1:0] cnt;
  logic          tmo;

  logic [OW-1:0] op_arr [NUM_REQ];
  logic [DW-1:0] a_arr  [NUM_REQ];
  logic [DW-1:0] b_arr  [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_op[i*OW +: OW];
      a_arr[i]  = req_a[i*DW +: DW];
      b_arr[i]  = req_b[i*DW +: DW];
    end
  end

  // first pending requester at or above ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (found) next = ISSUE;
      ISSUE:   if (alu_ready) next = WAIT;
      WAIT:    if (alu_done || tmo) next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      state     <= next;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            req_ready[win] <= 1'b1;
            owner          <= win;
            alu_op         <= op_arr[win];
            alu_a          <= a_arr[win];
            alu_b          <= b_arr[win];
            alu_valid      <= 1'b1;
          end
        end
        ISSUE: begin
          if (alu_ready) alu_valid <= 1'b0;
        end
        WAIT: begin
          // done beats a timeout landing on the same edge
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_error  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_id     <= owner;
          end else if (tmo) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_id     <= owner;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and randomized checks of alu_req_arbiter
// against a transaction-level round-robin / timeout model.
module tb_alu_req_arbiter;

  localparam int N  = 4;
  localparam int OW = 3;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*OW-1:0] req_op = '0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [RW-1:0]   rsp_result;
  logic            rsp_error;
  logic            alu_ready = 1'b0;
  logic            alu_valid;
  logic [OW-1:0]   alu_op;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic            alu_done = 1'b0;
  logic [RW-1:0]   alu_result = '0;

  int n_cmp = 0;
  int n_err = 0;
  int mptr  = 0;
  bit keep [N];

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .NUM_REQ(N),
    .ALU_IN_OP_WIDTH(OW),
    .ALU_IN_OPERAND_WIDTH(DW),
    .ALU_OUT_RESULT_WIDTH(RW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_result(rsp_result),
    .rsp_error(rsp_error),
    .alu_ready(alu_ready),
    .alu_valid(alu_valid),
    .alu_op(alu_op),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_done(alu_done),
    .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_error,
                alu_valid, alu_op, alu_a, alu_b});
  endfunction

  task automatic set_req(input int i, input bit v);
    if (v) begin
      req_valid = req_valid | (N'(1) << i);
      req_op[i*OW +: OW] = OW'($urandom);
      req_a[i*DW +: DW]  = DW'($urandom);
      req_b[i*DW +: DW]  = DW'($urandom);
    end else begin
      req_valid = req_valid & ~(N'(1) << i);
    end
  endtask

  task automatic set_req_d(input int i, input logic [OW-1:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    set_req(i, 1'b1);
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
  endtask

  // model: first pending requester counting up from mptr modulo N
  function automatic int pick();
    int j;
    for (int k = 0; k < N; k++) begin
      j = (mptr + k) % N;
      if (((req_valid >> j) & N'(1)) != '0) return j;
    end
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    chk("reset_outputs", all_out(), 64'd0);
    rst  = 1'b1;
    mptr = 0;
  endtask

  task automatic do_txn(input int rdy_wait, input int done_wait,
                        input bit done_en, input logic [RW-1:0] res,
                        output int w);
    logic [OW-1:0] eop;
    logic [DW-1:0] ea, eb;
    logic [RW-1:0] eres;
    int            exp_tick, seen;
    bit            eerr;
    w   = pick();
    eop = req_op[w*OW +: OW];
    ea  = req_a[w*DW +: DW];
    eb  = req_b[w*DW +: DW];
    alu_ready = 1'($urandom);
    alu_done  = 1'b0;
    tick();
    chk("grant", 64'(req_ready), 64'(N'(1) << w));
    chk("issue_valid", 64'(alu_valid), 64'd1);
    chk("issue_data", 64'({alu_op, alu_a, alu_b}), 64'({eop, ea, eb}));
    if (keep[w]) set_req(w, 1'b1);
    else set_req(w, 1'b0);
    for (int k = 0; k < rdy_wait; k++) begin
      alu_ready = 1'b0;
      alu_done  = 1'($urandom);
      tick();
      chk("hold_valid", 64'({req_ready, alu_valid}), 64'd1);
      chk("hold_data", 64'({alu_op, alu_a, alu_b}), 64'({eop, ea, eb}));
    end
    alu_ready = 1'b1;
    alu_done  = 1'($urandom);
    tick();
    chk("handshake", 64'({req_ready, alu_valid, rsp_valid}), 64'd0);
    alu_ready = 1'b0;
    if (done_en && done_wait + 1 <= TO) begin
      exp_tick = done_wait + 1;
      eerr     = 1'b0;
      eres     = res;
    end else begin
      exp_tick = TO;
      eerr     = 1'b1;
      eres     = '0;
    end
    seen = 0;
    for (int t = 1; t <= TO + 20; t++) begin
      alu_done   = done_en && (t == done_wait + 1);
      alu_result = alu_done ? res : RW'($urandom);
      tick();
      if (rsp_valid === 1'b1) begin
        seen = t;
        break;
      end
      chk("wait_quiet", 64'({req_ready, alu_valid}), 64'd0);
    end
    alu_done = 1'($urandom);
    chk("rsp_latency", 64'(seen), 64'(exp_tick));
    chk("rsp_id", 64'(rsp_id), 64'(w));
    chk("rsp_error", 64'(rsp_error), 64'(eerr));
    chk("rsp_result", 64'(rsp_result), 64'(eres));
    tick();
    alu_done = 1'b0;
    chk("rsp_pulse", 64'({rsp_valid, req_ready, alu_valid}), 64'd0);
    chk("rsp_hold", 64'({rsp_id, rsp_error, rsp_result}),
        64'({2'(w), eerr, eres}));
    mptr = (w + 1) % N;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int w;
    for (int i = 0; i < N; i++) keep[i] = 1'b0;

    #2 rst = 1'b0;
    #1 chk("async_reset", all_out(), 64'd0);
    tick();
    tick();
    chk("reset_hold", all_out(), 64'd0);
    rst = 1'b1;

    // single request from requester 2
    set_req_d(2, 3'd1, 8'h05, 8'h03);
    do_txn(0, 2, 1'b1, 16'h0008, w);
    chk("single_owner", 64'(w), 64'd2);

    // round robin with every requester holding its request
    do_reset();
    for (int i = 0; i < N; i++) begin
      keep[i] = 1'b1;
      set_req(i, 1'b1);
    end
    for (int k = 0; k < 6; k++) begin
      do_txn(0, k, 1'b1, RW'($urandom), w);
      chk("rr_order", 64'(w), 64'(k % N));
    end
    for (int i = 0; i < N; i++) keep[i] = 1'b0;
    req_valid = '0;

    // back-pressure then timeout then normal service
    set_req(1, 1'b1);
    do_txn(5, 3, 1'b1, 16'h1234, w);
    set_req(0, 1'b1);
    do_txn(0, 0, 1'b0, 16'h0000, w);
    chk("timeout_owner", 64'(w), 64'd0);
    set_req(0, 1'b1);
    set_req(2, 1'b1);
    do_txn(1, 4, 1'b1, 16'hBEEF, w);
    chk("after_timeout", 64'(w), 64'd2);
    req_valid = '0;

    // done on the final wait cycle beats the timeout
    set_req(1, 1'b1);
    do_txn(0, TO - 1, 1'b1, 16'h00FF, w);

    // reset while the ALU owes a result
    set_req(2, 1'b1);
    alu_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1 chk("reset_mid_op", all_out(), 64'd0);
    alu_done   = 1'b1;
    alu_result = 16'hAAAA;
    tick();
    chk("reset_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    rst      = 1'b1;
    mptr     = 0;
    alu_done = 1'b0;
    tick();
    chk("post_reset_quiet", all_out(), 64'd0);
    set_req(1, 1'b1);
    set_req(3, 1'b1);
    do_txn(0, 1, 1'b1, 16'h0101, w);
    chk("ptr_cleared", 64'(w), 64'd1);
    req_valid = '0;
    set_req(3, 1'b1);
    do_txn(0, 2, 1'b1, 16'h0303, w);
    chk("req3_alone", 64'(w), 64'd3);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      if (req_valid == '0) begin
        set_req(int'($urandom_range(0, N - 1)), 1'b1);
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 1) == 1) set_req(i, 1'b1);
      end
      for (int i = 0; i < N; i++) keep[i] = ($urandom_range(0, 2) == 0);
      do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 70)),
             ($urandom_range(0, 5) != 0), RW'($urandom), w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
